// File: rtl/button_ctrl.sv
// button_ctrl
// Front-panel conditioner for the LED blinker controls. Four raw, bouncing,
// asynchronous pushbuttons are synchronised, debounced per key and turned into:
//   - press pulses for pause (key 0) and soft reset (key 3),
//   - a saturating 4-bit delay setting stepped by down (key 1) / up (key 2)
//     keys, with auto-repeat while a step key is held.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   key_raw    in   [3:0] raw keys (0 pause, 1 down, 2 up, 3 soft reset)
//   key_state  out  [3:0] debounced pressed levels, 1 = pressed
//   pause      out  one-cycle pulse per debounced press of key 0
//   soft_reset out  one-cycle pulse per debounced press of key 3
//   delay      out  [3:0] current delay setting
module button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int DELAY_INIT      = 8,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_raw,
    output logic [3:0] key_state,
    output logic       pause,
    output logic       soft_reset,
    output logic [3:0] delay
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] WAIT_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);
    localparam logic [3:0]      DELAY_RST  = 4'(DELAY_INIT);
    // Raw level of an unpressed key; the synchronisers start from it so that
    // reset never looks like a press.
    localparam logic [3:0]      RAW_IDLE   = (KEY_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_WAIT,
        RPT_REPEAT
    } rpt_state_t;

    logic [3:0]      sync1_reg;
    logic [3:0]      sync2_reg;
    logic [3:0]      key_sync;
    logic [3:0]      key_state_reg;
    logic [3:0]      key_state_next;
    logic [3:0]      key_prev_reg;
    logic [3:0]      key_rise;
    logic [DB_W-1:0] db_cnt_reg  [4];
    logic [DB_W-1:0] db_cnt_next [4];
    logic            pause_reg;
    logic            soft_reset_reg;
    logic [3:0]      delay_reg;
    logic [1:0]      step;          // bit 0 = down step, bit 1 = up step
    logic            both_held;

    // Pressed level, independent of board polarity.
    assign key_sync  = (KEY_ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;
    assign key_rise  = key_state_reg & ~key_prev_reg;
    assign both_held = key_state_reg[1] & key_state_reg[2];

    // Per-key debounce: the counter only survives consecutive cycles of
    // disagreement, so any glitch shorter than DEBOUNCE_CYCLES is dropped.
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
        logic differ;
        logic done;
        assign differ            = key_sync[gi] ^ key_state_reg[gi];
        assign done              = differ && (db_cnt_reg[gi] == DB_LAST);
        assign db_cnt_next[gi]   = (differ && !done) ? db_cnt_reg[gi] + 1'b1 : '0;
        assign key_state_next[gi] = key_state_reg[gi] ^ done;
    end

    // Repeat FSMs: instance 0 serves key 1 (down), instance 1 serves key 2 (up).
    for (genvar gi = 0; gi < 2; gi++) begin : g_rpt
        rpt_state_t      state_reg;
        logic [RP_W-1:0] cnt_reg;
        logic            held;
        assign held = key_state_reg[gi+1];

        // An IDLE FSM with the key held but no new edge only happens after a
        // dual press resolves; it resumes in WAIT without stepping.
        assign step[gi] = held && !both_held &&
                          (((state_reg == RPT_IDLE)   && key_rise[gi+1]) ||
                           ((state_reg == RPT_WAIT)   && (cnt_reg == WAIT_LAST)) ||
                           ((state_reg == RPT_REPEAT) && (cnt_reg == RATE_LAST)));

        always_ff @(posedge clk) begin
            if (reset || !held || both_held) begin
                state_reg <= RPT_IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    RPT_IDLE: begin
                        state_reg <= RPT_WAIT;
                        cnt_reg   <= '0;
                    end
                    RPT_WAIT: begin
                        if (cnt_reg == WAIT_LAST) begin
                            state_reg <= RPT_REPEAT;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    RPT_REPEAT: begin
                        if (cnt_reg == RATE_LAST) cnt_reg <= '0;
                        else                      cnt_reg <= cnt_reg + 1'b1;
                    end
                    default: begin
                        state_reg <= RPT_IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg      <= RAW_IDLE;
            sync2_reg      <= RAW_IDLE;
            key_state_reg  <= '0;
            key_prev_reg   <= '0;
            pause_reg      <= 1'b0;
            soft_reset_reg <= 1'b0;
            delay_reg      <= DELAY_RST;
            for (int k = 0; k < 4; k++) db_cnt_reg[k] <= '0;
        end else begin
            sync1_reg      <= key_raw;
            sync2_reg      <= sync1_reg;
            key_state_reg  <= key_state_next;
            key_prev_reg   <= key_state_reg;
            pause_reg      <= key_rise[0];
            soft_reset_reg <= key_rise[3];
            for (int k = 0; k < 4; k++) db_cnt_reg[k] <= db_cnt_next[k];
            // Soft reset wins over a step landing in the same cycle.
            if (key_rise[3]) begin
                delay_reg <= DELAY_RST;
            end else if (step[1] && !step[0]) begin
                if (delay_reg != 4'hF) delay_reg <= delay_reg + 4'd1;
            end else if (step[0] && !step[1]) begin
                if (delay_reg != 4'h0) delay_reg <= delay_reg - 4'd1;
            end
        end
    end

    assign key_state  = key_state_reg;
    assign pause      = pause_reg;
    assign soft_reset = soft_reset_reg;
    assign delay      = delay_reg;

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl. Stimulus pushes the expected output
// changes (value and clock edge) into per-output queues; a monitor samples the
// outputs on the falling edge and pops/compares on every observed change.
module tb_button_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key_raw;
    logic [3:0] key_state;
    logic       pause;
    logic       soft_reset;
    logic [3:0] delay;

    button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_RATE    (3),
        .DELAY_INIT     (8),
        .KEY_ACTIVE_LOW (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key_raw   (key_raw),
        .key_state (key_state),
        .pause     (pause),
        .soft_reset(soft_reset),
        .delay     (delay)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] val;
        int         cyc;
    } exp_t;

    exp_t q_ks[$];
    exp_t q_pause[$];
    exp_t q_srst[$];
    exp_t q_delay[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;
    logic mon_init = 1'b0;
    logic [3:0] prev_ks, prev_delay;
    logic       prev_pause, prev_srst;

    localparam int S_KS = 0, S_PAUSE = 1, S_SRST = 2, S_DELAY = 3;

    function automatic string sig_name(input int sig);
        case (sig)
            S_KS:    return "key_state";
            S_PAUSE: return "pause";
            S_SRST:  return "soft_reset";
            default: return "delay";
        endcase
    endfunction

    task automatic push(input int sig, input logic [3:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        case (sig)
            S_KS:    q_ks.push_back(e);
            S_PAUSE: q_pause.push_back(e);
            S_SRST:  q_srst.push_back(e);
            default: q_delay.push_back(e);
        endcase
    endtask

    task automatic check_ev(input int sig, input logic [3:0] act);
        exp_t e;
        logic got;
        got = 1'b0;
        e.val = '0;
        e.cyc = 0;
        case (sig)
            S_KS:    if (q_ks.size()    > 0) begin e = q_ks.pop_front();    got = 1'b1; end
            S_PAUSE: if (q_pause.size() > 0) begin e = q_pause.pop_front(); got = 1'b1; end
            S_SRST:  if (q_srst.size()  > 0) begin e = q_srst.pop_front();  got = 1'b1; end
            default: if (q_delay.size() > 0) begin e = q_delay.pop_front(); got = 1'b1; end
        endcase
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s: unexpected change to %0h at cycle %0d, no change required",
                     sig_name(sig), act, cyc);
        end else if (e.val !== act || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: got %0h at cycle %0d, required %0h at cycle %0d",
                     sig_name(sig), act, cyc, e.val, e.cyc);
        end else begin
            $display("ok   %s = %0h at cycle %0d", sig_name(sig), act, cyc);
        end
    endtask

    task automatic check_now(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Monitor: reset values once, then every output change is a transaction.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!mon_init) begin
                check_now("reset key_state", key_state, 4'h0);
                check_now("reset pause", {3'b0, pause}, 4'h0);
                check_now("reset soft_reset", {3'b0, soft_reset}, 4'h0);
                check_now("reset delay", delay, 4'h8);
                mon_init = 1'b1;
            end else begin
                if (key_state !== prev_ks)   check_ev(S_KS, key_state);
                if (pause !== prev_pause)    check_ev(S_PAUSE, {3'b0, pause});
                if (soft_reset !== prev_srst) check_ev(S_SRST, {3'b0, soft_reset});
                if (delay !== prev_delay)    check_ev(S_DELAY, delay);
            end
            prev_ks    = key_state;
            prev_pause = pause;
            prev_srst  = soft_reset;
            prev_delay = delay;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic press(input int k);
        key_raw[k] = 1'b0;
    endtask

    task automatic release_key(input int k);
        key_raw[k] = 1'b1;
    endtask

    initial begin
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, s, t0, p, q, u, r;
        reset   = 1'b1;
        key_raw = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (5) tick();

        // Clean press of key 0.
        c = cyc;
        press(0);
        push(S_KS, 4'h1, c + 6);
        push(S_PAUSE, 4'h1, c + 7);
        push(S_PAUSE, 4'h0, c + 8);
        wait_until(c + 20);
        release_key(0);
        push(S_KS, 4'h0, c + 26);
        wait_until(c + 40);

        // Bouncing key 0: 2-cycle toggles, then settle pressed.
        c = cyc;
        for (int k = 0; k < 6; k++) begin
            wait_until(c + 2 * k);
            if (k % 2 == 0) press(0);
            else            release_key(0);
        end
        wait_until(c + 12);
        s = cyc;
        press(0);
        push(S_KS, 4'h1, s + 6);
        push(S_PAUSE, 4'h1, s + 7);
        push(S_PAUSE, 4'h0, s + 8);
        wait_until(s + 20);
        release_key(0);
        push(S_KS, 4'h0, s + 26);
        wait_until(s + 40);

        // Auto-repeat up from 8, saturating at 15.
        c = cyc;
        t0 = c + 7;
        press(2);
        push(S_KS, 4'h4, c + 6);
        push(S_DELAY, 4'd9, t0);
        push(S_DELAY, 4'd10, t0 + 10);
        for (int k = 0; k < 5; k++) push(S_DELAY, 4'(11 + k), t0 + 13 + 3 * k);
        wait_until(t0 + 30);
        r = cyc;
        release_key(2);
        push(S_KS, 4'h0, r + 6);
        wait_until(r + 20);

        // Down from 15 to 1 by repeat, then release before the next step.
        c = cyc;
        t0 = c + 7;
        press(1);
        push(S_KS, 4'h2, c + 6);
        push(S_DELAY, 4'd14, t0);
        push(S_DELAY, 4'd13, t0 + 10);
        for (int k = 1; k <= 12; k++) push(S_DELAY, 4'(13 - k), t0 + 10 + 3 * k);
        wait_until(t0 + 41);
        release_key(1);
        push(S_KS, 4'h0, t0 + 47);
        wait_until(t0 + 60);

        // Down saturation at 0, then dual press and release of key 1.
        p = cyc;
        press(1);
        push(S_KS, 4'h2, p + 6);
        push(S_DELAY, 4'd0, p + 7);
        wait_until(p + 27);
        q = cyc;
        press(2);
        push(S_KS, 4'h6, q + 6);
        wait_until(q + 20);
        u = cyc;
        release_key(1);
        push(S_KS, 4'h4, u + 6);
        push(S_DELAY, 4'd1, u + 17);
        wait_until(u + 12);
        release_key(2);
        push(S_KS, 4'h0, u + 18);
        wait_until(u + 40);

        // Soft reset colliding with a repeat step at delay 12.
        c = cyc;
        t0 = c + 7;
        press(2);
        push(S_KS, 4'h4, c + 6);
        push(S_DELAY, 4'd2, t0);
        push(S_DELAY, 4'd3, t0 + 10);
        for (int k = 1; k <= 9; k++) push(S_DELAY, 4'(3 + k), t0 + 10 + 3 * k);
        wait_until(t0 + 33);
        press(3);
        push(S_KS, 4'hC, t0 + 39);
        push(S_SRST, 4'h1, t0 + 40);
        push(S_SRST, 4'h0, t0 + 41);
        push(S_DELAY, 4'd8, t0 + 40);
        push(S_DELAY, 4'd9, t0 + 43);
        wait_until(t0 + 38);
        release_key(2);
        push(S_KS, 4'h8, t0 + 44);
        wait_until(t0 + 40);
        release_key(3);
        push(S_KS, 4'h0, t0 + 46);
        wait_until(t0 + 60);

        // Reset for one cycle while key 2 is repeating and still held.
        c = cyc;
        t0 = c + 7;
        press(2);
        push(S_KS, 4'h4, c + 6);
        push(S_DELAY, 4'd10, t0);
        push(S_DELAY, 4'd11, t0 + 10);
        push(S_DELAY, 4'd12, t0 + 13);
        push(S_DELAY, 4'd13, t0 + 16);
        wait_until(t0 + 17);
        reset = 1'b1;
        push(S_KS, 4'h0, t0 + 18);
        push(S_DELAY, 4'd8, t0 + 18);
        wait_until(t0 + 18);
        reset = 1'b0;
        push(S_KS, 4'h4, t0 + 24);
        push(S_DELAY, 4'd9, t0 + 25);
        wait_until(t0 + 26);
        release_key(2);
        push(S_KS, 4'h0, t0 + 32);
        wait_until(t0 + 50);

        check_now("pending key_state events", 4'(q_ks.size()), 4'h0);
        check_now("pending pause events", 4'(q_pause.size()), 4'h0);
        check_now("pending soft_reset events", 4'(q_srst.size()), 4'h0);
        check_now("pending delay events", 4'(q_delay.size()), 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
Name: button_ctrl

Overview:
- Front-panel input conditioner that produces the control inputs for the LED blinker: `pause`, soft reset, and the 4-bit `delay` setting.
- Takes four raw, asynchronous, bouncing pushbuttons and applies synchronisation and per-key debounce.
- Generates single-cycle press pulses, and holds a saturating delay register stepped by up/down keys with auto-repeat.
- Sits between the board KEY pins and the blinker in the top level.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a synchronised key must differ from its debounced level before the debounced level flips (20 ms at 50 MHz). Minimum 1.
- REPEAT_DELAY, 25000000: cycles a step key must stay held after its first step before auto-repeat starts.
- REPEAT_RATE, 5000000: cycles between auto-repeat steps.
- DELAY_INIT, 8: value of `delay` after reset or soft reset, range 0..15.
- KEY_ACTIVE_LOW, 1: 1 = raw keys read 0 when pressed; 0 = read 1 when pressed.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_raw  in  4  raw pushbuttons, asynchronous. Bit 0 = pause, bit 1 = delay down, bit 2 = delay up, bit 3 = soft reset.
- key_state  out  4  debounced pressed levels, 1 = pressed.
- pause  out  1  one-cycle pulse per debounced press of key 0.
- soft_reset  out  1  one-cycle pulse per debounced press of key 3.
- delay  out  4  current delay setting.

Behaviour:
Reset (`reset` high at a clk edge):
- Synchroniser flops load the released level.
- `key_state` = 0, `pause` = 0, `soft_reset` = 0, `delay` = DELAY_INIT.
- Debounce and repeat counters clear; both repeat FSMs go to IDLE.
- Takes effect at that edge and overrides all other activity, including reset asserted mid-repeat or mid-debounce.
- A key held through reset is seen as a new press once reset drops, after the normal debounce latency.

Synchroniser:
- Two flops per key, then polarity normalisation per KEY_ACTIVE_LOW.

Debounce, per key:
- Counter increments while the synchronised level differs from `key_state[i]`.
- Counter clears on any cycle where they agree.
- When the counter reaches DEBOUNCE_CYCLES-1 while still differing, `key_state[i]` flips and the counter clears.
- Latency from a stable raw change to `key_state` change: DEBOUNCE_CYCLES+2 cycles. Async sampling may add one cycle.
- A glitch shorter than DEBOUNCE_CYCLES never changes `key_state`.

Press pulses:
- `pause` = registered rising edge of `key_state[0]`; `soft_reset` = registered rising edge of `key_state[3]`.
- Each is high exactly one cycle, the cycle after `key_state` rises.
- No pulse on release.
- Both may pulse in the same cycle.

Repeat FSM, one each for up (key 2) and down (key 1):
- IDLE: on `key_state` rising edge, issue one step and go to WAIT with counter 0.
- WAIT: count; at REPEAT_DELAY-1, issue a step, clear the counter, go to REPEAT.
- REPEAT: count; at REPEAT_RATE-1, issue a step and clear the counter.
- Key released in any state: go to IDLE immediately, no step.
- Steps are registered: `delay` updates one cycle after the step condition, i.e. in the same cycle `pause` would pulse for an equivalent press.

Both step keys pressed:
- While both are held, no steps are issued and both FSMs are forced to IDLE.
- When one releases, the still-held key enters WAIT with counter 0. It issues no immediate step, because there is no new edge.

Delay arithmetic:
- Up step: `delay` = min(`delay`+1, 15). Down step: `delay` = max(`delay`-1, 0). No wrap-around.
- Soft reset has priority: in the cycle `soft_reset` is high, `delay` loads DELAY_INIT and any step in that cycle is discarded. The repeat FSMs keep running.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, DELAY_INIT=8, KEY_ACTIVE_LOW=1.)
- Clean press: drive `key_raw[0]` 1→0 and hold 20 cycles, then release → `key_state[0]` rises 6 cycles after the change (±1). `pause` is high for exactly one cycle, 7 cycles after the change. No pulse on release.
- Bounce: toggle `key_raw[0]` every 2 cycles for 12 cycles, then hold 0 → no `pause` and no `key_state` change during bouncing. Exactly one `pause` 7 cycles after settling.
- Auto-repeat up: hold key 2 from `delay`=8 → 9 at press (t0), 10 at t0+10, 11/12/13/14/15 at t0+13/16/19/22/25. Stays 15 at t0+28. Release → no further change.
- Down saturation and dual press: from `delay`=1, press key 1 → 0; keep holding 20 cycles → stays 0. Then also press key 2 → no change while both are held. Release key 1 → first up step 10 cycles later (`delay`=1).
- Soft reset: `delay`=12 with key 2 in REPEAT, press key 3 so its pulse coincides with a repeat step → `soft_reset` one-cycle pulse, `delay`=8 (step discarded). Next repeat step 3 cycles later gives 9.
- Reset mid-operation: assert `reset` one cycle during REPEAT with key 2 still held → next cycle `delay`=8, `key_state`=0, no pulses. A press step occurs 6 cycles after `reset` deasserts (`delay`=9).
